mips_trace_buffer: RTL and testbench
====================================

Name: mips_trace_buffer

Overview:
- Synthesizable, parametrised instruction-trace capture block that replaces ad-hoc console monitoring of the CPU's PC/instruction stream.
- Sits beside mips_top: taps PC, instruction and wb_value, and keeps a ring buffer of the last DEPTH retired-instruction samples.
- Freezes the buffer on a PC-match trigger or on a hang (PC stuck), then exposes the contents oldest-first over a valid/ready read port.

Parameters:
- DATA_W, 32, width of pc, instruction and wb_value.
- DEPTH, 16, ring entries; power of 2, minimum 4.
- POST_TRIG, 8, entries captured after the trigger entry; range 0..DEPTH-1.
- HANG_CYCLES, 64, consecutive cycles of unchanged PC (with cap_en high) that raise hang.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cap_en  in  1  sample qualifier; CPU running.
- pc  in  DATA_W  current PC.
- instruction  in  DATA_W  current instruction word.
- wb_value  in  DATA_W  current writeback value.
- arm  in  1  single-cycle pulse: clear the buffer and start capture.
- trig_en  in  1  enables the PC-match trigger.
- trig_pc  in  DATA_W  trigger address.
- rd_ready  in  1  reader accepts the entry.
- rd_valid  out  1  entry available.
- rd_pc, rd_instr, rd_wb  out  DATA_W each  entry fields.
- count  out  $clog2(DEPTH+1)  valid entries held.
- triggered  out  1  sticky; PC-match trigger seen.
- hang  out  1  sticky; hang detected.
- busy  out  1  state is ARMED or POST.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; count, wr_ptr, post_cnt, hang_cnt = 0; triggered=0; hang=0; rd_valid=0; rd_* = 0; last_valid=0.
- Sample event, ARMED/POST only:
  - Condition: cap_en && (!last_valid || pc != last_pc).
  - Action: write {pc, instruction, wb_value} at wr_ptr; wr_ptr wraps modulo DEPTH; last_pc<=pc; last_valid<=1.
  - count saturates at DEPTH; when full, the oldest entry is overwritten.
- States:
  - IDLE:
    - No capture; rd_valid=0.
    - arm -> ARMED.
  - ARMED:
    - Sampling active.
    - A sample event with trig_en && pc==trig_pc sets triggered. That entry is stored.
    - On trigger, POST_TRIG==0 -> DONE at the same edge; otherwise post_cnt<=POST_TRIG and -> POST.
  - POST:
    - Each sample event stores the entry and decrements post_cnt.
    - The event storing the entry with post_cnt==1 -> DONE.
    - Further PC matches are ignored.
  - DONE:
    - Buffer frozen; no writes.
    - rd_valid=(count!=0).
    - rd_* present the entry at index (wr_ptr - count) mod DEPTH, combinationally from the registered pointers.
    - rd_valid && rd_ready decrements count at the edge; the next entry is visible the following cycle.
    - At most one pop per cycle.
    - count reaching 0 -> IDLE. triggered and hang remain set.
- Hang detector (ARMED/POST):
  - hang_cnt increments on each cycle with cap_en && last_valid && pc==last_pc; resets to 0 on any sample event; holds while cap_en=0.
  - hang_cnt reaching HANG_CYCLES-1 with the condition true sets hang and -> DONE at that edge.
  - hang_cnt saturates and does not wrap.
- arm priority:
  - arm has priority over every state transition, sample, pop and hang.
  - Next state is ARMED; count, wr_ptr, post_cnt, hang_cnt, triggered, hang and last_valid clear.
  - No sample is taken in the arm cycle.
  - Re-arming while in ARMED restarts capture.
- Simultaneous trigger and hang on the same edge: trigger takes precedence, so triggered=1 and hang=0.
- busy=1 in ARMED/POST.
- Latency: a sample appears in count one cycle after the edge where it is taken.

Decomposition:
- Shared package mips_trace_pkg holds:
  - state enum (IDLE, ARMED, POST, DONE);
  - entry width constant ENTRY_W = 3*DATA_W;
  - helper to compute the pointer width.
- One sub-module, trace_ram: DEPTH x ENTRY_W register array with one write port and one asynchronous read port.
- Control FSM, pointers and hang counter stay in the top module.

Test Plan:
1. Reset mid-capture: arm, feed 5 distinct PCs, assert reset -> count=0, rd_valid=0, busy=0, all flags 0 immediately (asynchronous).
2. Wrap + trigger: DEPTH=16, POST_TRIG=8, trig_pc=0x40. Arm, feed PCs 0x00,0x04,...,0x60 step 4 (25 samples) -> DONE after PC 0x60. count=16, triggered=1. Readout yields pc 0x24..0x60 in order.
3. Duplicate filtering: hold pc=0x10 for 3 cycles, then 0x14 -> exactly 2 entries stored, hang_cnt returns to 0.
4. Hang: HANG_CYCLES=64. Arm, pc=0x08 constant with cap_en=1 -> hang=1 and DONE 64 cycles after the first sample; count=1; rd_pc=0x08.
5. Readout backpressure: in DONE with count=4, toggle rd_ready 1,0,1,1,1 -> entries popped in order, none skipped or repeated; IDLE after the 4th pop; rd_valid=0.
6. arm during POST: arm pulse while post_cnt=3 -> next cycle ARMED, count=0, triggered=0; a new trigger works normally.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// Shared types and sizing helpers for the MIPS instruction-trace buffer.
package mips_trace_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ARMED = 2'd1;
   localparam state_t ST_POST  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Each entry packs {pc, instruction, wb_value}.
   localparam int ENTRY_FIELDS = 3;

   function automatic int entry_w(input int data_w);
      return ENTRY_FIELDS * data_w;
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mips_trace_buffer_ram.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one asynchronous read port.
module trace_ram #(
   parameter int DEPTH   = 16,
   parameter int ENTRY_W = 96,
   parameter int PTR_W   = 4
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [PTR_W-1:0]   wr_addr,
   input  logic [ENTRY_W-1:0] wr_dat,
   input  logic [PTR_W-1:0]   rd_addr,
   output logic [ENTRY_W-1:0] rd_dat
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Ring-buffer capture of retired PC/instruction/wb samples, frozen on PC match or hang.
// Samples show in count one cycle after capture; readout is valid/ready, one pop per cycle.
module mips_trace_buffer
   import mips_trace_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int POST_TRIG   = 8,
   parameter int HANG_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cap_en,
   input  logic [DATA_W-1:0]          pc,
   input  logic [DATA_W-1:0]          instruction,
   input  logic [DATA_W-1:0]          wb_value,
   input  logic                       arm,
   input  logic                       trig_en,
   input  logic [DATA_W-1:0]          trig_pc,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_pc,
   output logic [DATA_W-1:0]          rd_instr,
   output logic [DATA_W-1:0]          rd_wb,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       triggered,
   output logic                       hang,
   output logic                       busy
);

   localparam int ENTRY_W = entry_w(DATA_W);
   localparam int PTR_W   = ptr_w(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH+1);
   localparam int HC_W    = $clog2(HANG_CYCLES+1);

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] POST_C    = PTR_W'(POST_TRIG);
   localparam logic [HC_W-1:0]  HANG_LAST = HC_W'(HANG_CYCLES-1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   post_cnt_q, post_cnt_d;
   logic [HC_W-1:0]    hang_cnt_q, hang_cnt_d;
   logic               triggered_q, triggered_d;
   logic               hang_q, hang_d;
   logic               last_valid_q, last_valid_d;
   logic [DATA_W-1:0]  last_pc_q, last_pc_d;

   logic               sampling;
   logic               sample_evt;
   logic               stuck;
   logic               pop;
   logic               wr_en;
   logic [PTR_W-1:0]   rd_addr;
   logic [ENTRY_W-1:0] rd_dat;

   assign sampling   = (state_q == ST_ARMED) || (state_q == ST_POST);
   assign sample_evt = sampling && cap_en && (!last_valid_q || (pc != last_pc_q));
   assign stuck      = sampling && cap_en && last_valid_q && (pc == last_pc_q);
   assign rd_valid   = (state_q == ST_DONE) && (count_q != '0);
   assign pop        = rd_valid && rd_ready;

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      post_cnt_d   = post_cnt_q;
      hang_cnt_d   = hang_cnt_q;
      triggered_d  = triggered_q;
      hang_d       = hang_q;
      last_valid_d = last_valid_q;
      last_pc_d    = last_pc_q;
      wr_en        = 1'b0;

      // arm overrides everything, including a sample presented in the same cycle
      if (arm) begin
         state_d      = ST_ARMED;
         count_d      = '0;
         wr_ptr_d     = '0;
         post_cnt_d   = '0;
         hang_cnt_d   = '0;
         triggered_d  = 1'b0;
         hang_d       = 1'b0;
         last_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_ARMED, ST_POST: begin
               if (sample_evt) begin
                  wr_en        = 1'b1;
                  wr_ptr_d     = wr_ptr_q + 1'b1;
                  last_pc_d    = pc;
                  last_valid_d = 1'b1;
                  hang_cnt_d   = '0;
                  if (count_q != DEPTH_C) begin
                     count_d = count_q + 1'b1;
                  end
                  if ((state_q == ST_ARMED) && trig_en && (pc == trig_pc)) begin
                     triggered_d = 1'b1;
                     if (POST_TRIG == 0) begin
                        state_d = ST_DONE;
                     end else begin
                        post_cnt_d = POST_C;
                        state_d    = ST_POST;
                     end
                  end else if (state_q == ST_POST) begin
                     post_cnt_d = post_cnt_q - 1'b1;
                     if (post_cnt_q == PTR_W'(1)) begin
                        state_d = ST_DONE;
                     end
                  end
               end else if (stuck) begin
                  if (hang_cnt_q == HANG_LAST) begin
                     hang_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     hang_cnt_d = hang_cnt_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (pop) begin
                  count_d = count_q - 1'b1;
                  if (count_q == CNT_W'(1)) begin
                     state_d = ST_IDLE;
                  end
               end else if (count_q == '0) begin
                  state_d = ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         post_cnt_q   <= '0;
         hang_cnt_q   <= '0;
         triggered_q  <= 1'b0;
         hang_q       <= 1'b0;
         last_valid_q <= 1'b0;
         last_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         post_cnt_q   <= post_cnt_d;
         hang_cnt_q   <= hang_cnt_d;
         triggered_q  <= triggered_d;
         hang_q       <= hang_d;
         last_valid_q <= last_valid_d;
         last_pc_q    <= last_pc_d;
      end
   end

   // Oldest entry sits count slots behind the write pointer; a full ring aliases to wr_ptr.
   assign rd_addr = wr_ptr_q - count_q[PTR_W-1:0];

   trace_ram #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W),
      .PTR_W   (PTR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_dat  ({pc, instruction, wb_value}),
      .rd_addr (rd_addr),
      .rd_dat  (rd_dat)
   );

   assign rd_pc     = rd_valid ? rd_dat[ENTRY_W-1 -: DATA_W]  : '0;
   assign rd_instr  = rd_valid ? rd_dat[2*DATA_W-1 -: DATA_W] : '0;
   assign rd_wb     = rd_valid ? rd_dat[DATA_W-1:0]           : '0;
   assign count     = count_q;
   assign triggered = triggered_q;
   assign hang      = hang_q;
   assign busy      = sampling;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer with a queue-based reference model checked every cycle.
module tb_mips_trace_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int POST  = 8;
   localparam int HANGC = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          cap_en;
   logic [DW-1:0] pc, instruction, wb_value, trig_pc;
   logic          arm, trig_en, rd_ready;
   logic          rd_valid, triggered, hang, busy;
   logic [DW-1:0] rd_pc, rd_instr, rd_wb;
   logic [4:0]    count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mips_trace_buffer #(
      .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(POST), .HANG_CYCLES(HANGC)
   ) dut (
      .clk(clk), .reset(reset), .cap_en(cap_en), .pc(pc),
      .instruction(instruction), .wb_value(wb_value), .arm(arm),
      .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wb(rd_wb),
      .count(count), .triggered(triggered), .hang(hang), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] p);
      return p ^ 32'hDEAD_0000;
   endfunction

   function automatic logic [31:0] wb_of(input logic [31:0] p);
      return p * 32'd3 + 32'd1;
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] wb;
   } ent_t;

   localparam int P_IDLE = 0, P_ARMED = 1, P_POST = 2, P_DONE = 3;

   ent_t        m_q[$];
   int          m_phase  = P_IDLE;
   bit          m_trig   = 0;
   bit          m_hang   = 0;
   bit          m_last_v = 0;
   logic [31:0] m_last_pc = '0;
   int          m_stuck  = 0;
   int          m_post   = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_phase = P_IDLE; m_trig = 0; m_hang = 0; m_last_v = 0; m_stuck = 0; m_post = 0;
      end else if (arm) begin
         m_q.delete();
         m_phase = P_ARMED; m_trig = 0; m_hang = 0; m_last_v = 0; m_stuck = 0; m_post = 0;
      end else if (m_phase == P_ARMED || m_phase == P_POST) begin
         if (cap_en && (!m_last_v || pc != m_last_pc)) begin
            m_q.push_back('{pc: pc, instr: instruction, wb: wb_value});
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            m_last_pc = pc; m_last_v = 1; m_stuck = 0;
            if (m_phase == P_ARMED && trig_en && pc == trig_pc) begin
               m_trig = 1;
               if (POST == 0) m_phase = P_DONE;
               else begin m_post = POST; m_phase = P_POST; end
            end else if (m_phase == P_POST) begin
               m_post--;
               if (m_post == 0) m_phase = P_DONE;
            end
         end else if (cap_en && m_last_v) begin
            m_stuck++;
            if (m_stuck == HANGC) begin m_hang = 1; m_phase = P_DONE; end
         end
      end else if (m_phase == P_DONE) begin
         if (m_q.size() != 0 && rd_ready) void'(m_q.pop_front());
         if (m_q.size() == 0) m_phase = P_IDLE;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         bit exp_v;
         exp_v = (m_phase == P_DONE) && (m_q.size() != 0);
         check("cmp_count", 32'(count), 32'(m_q.size()));
         check("cmp_rd_valid", 32'(rd_valid), 32'(exp_v));
         check("cmp_triggered", 32'(triggered), 32'(m_trig));
         check("cmp_hang", 32'(hang), 32'(m_hang));
         check("cmp_busy", 32'(busy), 32'(m_phase == P_ARMED || m_phase == P_POST));
         if (exp_v) begin
            check("cmp_rd_pc", rd_pc, m_q[0].pc);
            check("cmp_rd_instr", rd_instr, m_q[0].instr);
            check("cmp_rd_wb", rd_wb, m_q[0].wb);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] p);
      pc = p; instruction = instr_of(p); wb_value = wb_of(p);
   endtask

   task automatic arm_pulse();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] got[$];
      int pat[5] = '{1, 0, 1, 1, 1};
      int drained;

      reset = 1'b1; cap_en = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
      drive(32'h0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst_count", 32'(count), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_flags", {30'd0, triggered, hang}, 0);
      check("rst_rd_pc", rd_pc, 0);

      // 1: asynchronous reset in the middle of a capture
      arm_pulse();
      cap_en = 1'b1;
      for (int i = 0; i < 5; i++) begin drive(32'h1000 + 32'(4*i)); tick(); end
      check("t1_count_before", 32'(count), 5);
      check("t1_busy_before", 32'(busy), 1);
      reset = 1'b1;
      #1;
      check("t1_count_async", 32'(count), 0);
      check("t1_busy_async", 32'(busy), 0);
      check("t1_valid_async", 32'(rd_valid), 0);
      check("t1_flags_async", {30'd0, triggered, hang}, 0);
      tick(); tick();
      reset = 1'b0;
      cap_en = 1'b0;
      tick();

      // 2: ring wrap and PC-match trigger with post-trigger capture
      trig_en = 1'b1; trig_pc = 32'h40;
      arm_pulse();
      cap_en = 1'b1;
      for (int i = 0; i < 25; i++) begin
         drive(32'(4*i));
         tick();
         if (i == 23) check("t2_busy_before_last", 32'(busy), 1);
      end
      cap_en = 1'b0;
      check("t2_triggered", 32'(triggered), 1);
      check("t2_count", 32'(count), 16);
      check("t2_busy", 32'(busy), 0);
      check("t2_hang", 32'(hang), 0);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t2_rd_valid", 32'(rd_valid), 1);
         check("t2_rd_pc", rd_pc, 32'h24 + 32'(4*i));
         tick();
      end
      rd_ready = 1'b0;
      check("t2_drained_valid", 32'(rd_valid), 0);
      check("t2_drained_count", 32'(count), 0);
      check("t2_trig_sticky", 32'(triggered), 1);

      // 3: duplicate PCs are filtered and reset the hang counter on a new sample
      trig_en = 1'b0;
      arm_pulse();
      cap_en = 1'b1;
      drive(32'h10);
      repeat (3) tick();
      drive(32'h14);
      tick();
      check("t3_count", 32'(count), 2);
      repeat (63) tick();
      check("t3_no_hang_yet", 32'(hang), 0);
      tick();
      check("t3_hang", 32'(hang), 1);
      check("t3_count_after", 32'(count), 2);

      // 4: hang exactly HANG_CYCLES cycles after the only sample; arm cycle takes no sample
      drive(32'h08);
      arm_pulse();
      check("t4_no_sample_in_arm", 32'(count), 0);
      repeat (64) tick();
      check("t4_hang_early", 32'(hang), 0);
      check("t4_busy_early", 32'(busy), 1);
      tick();
      check("t4_hang", 32'(hang), 1);
      check("t4_busy", 32'(busy), 0);
      check("t4_count", 32'(count), 1);
      check("t4_rd_pc", rd_pc, 32'h08);
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      check("t4_valid_after_pop", 32'(rd_valid), 0);

      // 5: readout under backpressure
      cap_en = 1'b0;
      arm_pulse();
      cap_en = 1'b1;
      for (int i = 0; i < 4; i++) begin drive(32'h100 + 32'(4*i)); tick(); end
      repeat (64) tick();
      check("t5_hang", 32'(hang), 1);
      check("t5_count", 32'(count), 4);
      for (int k = 0; k < 5; k++) begin
         rd_ready = pat[k][0];
         if (rd_valid && rd_ready) got.push_back(rd_pc);
         tick();
      end
      rd_ready = 1'b0;
      check("t5_pops", 32'(got.size()), 4);
      for (int j = 0; j < got.size(); j++) check("t5_order", got[j], 32'h100 + 32'(4*j));
      check("t5_valid_end", 32'(rd_valid), 0);
      check("t5_busy_end", 32'(busy), 0);

      // 6: re-arm during post-trigger capture, then a fresh trigger
      trig_en = 1'b1; trig_pc = 32'h200;
      cap_en = 1'b0;
      arm_pulse();
      cap_en = 1'b1;
      drive(32'h1F0); tick();
      drive(32'h200); tick();
      for (int i = 1; i <= 5; i++) begin drive(32'h200 + 32'(4*i)); tick(); end
      check("t6_count_post", 32'(count), 7);
      check("t6_trig_post", 32'(triggered), 1);
      drive(32'h218);
      arm_pulse();
      check("t6_count_rearm", 32'(count), 0);
      check("t6_trig_rearm", 32'(triggered), 0);
      check("t6_busy_rearm", 32'(busy), 1);
      drive(32'h300); tick();
      drive(32'h200); tick();
      for (int i = 1; i <= 8; i++) begin drive(32'h200 + 32'(4*i)); tick(); end
      check("t6_busy_done", 32'(busy), 0);
      check("t6_trig_done", 32'(triggered), 1);
      check("t6_count_done", 32'(count), 10);
      check("t6_head", rd_pc, 32'h300);
      cap_en = 1'b0;
      rd_ready = 1'b1;
      drained = 0;
      while (rd_valid && drained < 40) begin tick(); drained++; end
      rd_ready = 1'b0;
      check("t6_drained", 32'(drained), 10);
      check("t6_valid_end", 32'(rd_valid), 0);

      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
